// File: rtl/ifm_bsg_feeder_if.sv
// Input-word channel for ifm_bsg_feeder: one IWIDTH-bit feature word plus
// accumulation markers, moved with valid/ready (source is master, feeder is slave).
// Ports: ifm_valid, ifm_ready, ifm_data, ifm_first, ifm_last; len_log2 only
// when BSG_EARLY_TERM_EN is defined.
interface ifm_bsg_feeder_if #(
  parameter int IWIDTH = 8
`ifdef BSG_EARLY_TERM_EN
  , parameter int LWIDTH = $clog2(IWIDTH + 1)
`endif
);
  logic              ifm_valid;
  logic              ifm_ready;
  logic [IWIDTH-1:0] ifm_data;
  logic              ifm_first;
  logic              ifm_last;
`ifdef BSG_EARLY_TERM_EN
  logic [LWIDTH-1:0] len_log2;
`endif

  modport master (
    output ifm_valid,
    output ifm_data,
    output ifm_first,
    output ifm_last,
`ifdef BSG_EARLY_TERM_EN
    output len_log2,
`endif
    input  ifm_ready
  );

  modport slave (
    input  ifm_valid,
    input  ifm_data,
    input  ifm_first,
    input  ifm_last,
`ifdef BSG_EARLY_TERM_EN
    input  len_log2,
`endif
    output ifm_ready
  );
endinterface

// File: rtl/ifm_bsg_feeder.sv
// Row-edge feeder: turns each input word into a rate-coded bitstream
// (ifm_dff = data > bitrev(k)) and drives the PE-row strobes.
// Latency: word accepted in cycle t streams in cycles t+1..t+L, outputs registered.
// Backpressure: ifm_ready only while idle or on the last stream cycle, so
// back-to-back words stream with no bubble; a held ifm_valid waits losslessly.
// Ports: clk, rst (sync, active-high); ifm (slave side of ifm_bsg_feeder_if);
// ifm_dff, en_i, clr_i, en_o, clr_o, mac_done, busy to the PE chain.
// Optional: BSG_EARLY_TERM_EN adds len_log2, stream length 2^min(len_log2,IWIDTH).
module ifm_bsg_feeder #(
  parameter int IWIDTH = 8
`ifdef BSG_EARLY_TERM_EN
  , parameter int LWIDTH = $clog2(IWIDTH + 1)
`endif
) (
  input  logic            clk,
  input  logic            rst,
  ifm_bsg_feeder_if.slave ifm,
  output logic            ifm_dff,
  output logic            en_i,
  output logic            clr_i,
  output logic            en_o,
  output logic            clr_o,
  output logic            mac_done,
  output logic            busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, nxt_state;
  logic [IWIDTH-1:0] cnt, nxt_cnt;
  logic [IWIDTH-1:0] data_q, nxt_data;
  logic [IWIDTH-1:0] lenm1_q, nxt_lenm1;
  logic              first_q, nxt_first;
  logic              last_q, nxt_last;
  logic              accept;
  logic              at_last;
  logic [IWIDTH-1:0] acc_lenm1;

  // Bit-reversed counter: a low-discrepancy threshold sequence, so a full
  // stream sees every threshold exactly once and carries exactly data ones.
  function automatic logic [IWIDTH-1:0] bitrev(input logic [IWIDTH-1:0] v);
    logic [IWIDTH-1:0] r;
    for (int i = 0; i < IWIDTH; i++) r[i] = v[IWIDTH-1-i];
    return r;
  endfunction

`ifdef BSG_EARLY_TERM_EN
  logic [LWIDTH-1:0] len_clip;
  always_comb begin
    len_clip  = (ifm.len_log2 > LWIDTH'(IWIDTH)) ? LWIDTH'(IWIDTH) : ifm.len_log2;
    // Last index = 2^len - 1; shifting all-ones by IWIDTH yields 0, so len=IWIDTH gives all-ones.
    acc_lenm1 = ~({IWIDTH{1'b1}} << len_clip);
  end
`else
  assign acc_lenm1 = '1;
`endif

  assign at_last       = (cnt == lenm1_q);
  assign ifm.ifm_ready = !rst && ((state == IDLE) || ((state == STREAM) && at_last));
  assign accept        = ifm.ifm_valid && ifm.ifm_ready;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_data  = data_q;
    nxt_first = first_q;
    nxt_last  = last_q;
    nxt_lenm1 = lenm1_q;
    if (accept) begin
      nxt_state = STREAM;
      nxt_cnt   = '0;
      nxt_data  = ifm.ifm_data;
      nxt_first = ifm.ifm_first;
      nxt_last  = ifm.ifm_last;
      nxt_lenm1 = acc_lenm1;
    end else if (state == STREAM) begin
      if (at_last) nxt_state = IDLE;
      else         nxt_cnt   = cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they register in the same
  // cycle the stream index they describe becomes current.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      lenm1_q  <= '0;
      ifm_dff  <= 1'b0;
      en_i     <= 1'b0;
      clr_i    <= 1'b0;
      en_o     <= 1'b0;
      clr_o    <= 1'b0;
      mac_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      data_q  <= nxt_data;
      first_q <= nxt_first;
      last_q  <= nxt_last;
      lenm1_q <= nxt_lenm1;
      if (nxt_state == STREAM) begin
        ifm_dff  <= (nxt_data > bitrev(nxt_cnt));
        en_i     <= 1'b1;
        clr_i    <= 1'b0;
        en_o     <= 1'b1;
        clr_o    <= (nxt_cnt == '0) && nxt_first;
        mac_done <= (nxt_cnt == nxt_lenm1) && nxt_last;
        busy     <= 1'b1;
      end else begin
        // Idle holds the PE input bit register cleared.
        ifm_dff  <= 1'b0;
        en_i     <= 1'b0;
        clr_i    <= 1'b1;
        en_o     <= 1'b0;
        clr_o    <= 1'b0;
        mac_done <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifm_bsg_feeder.sv
// Directed bench for ifm_bsg_feeder (IWIDTH=8): reset, stream patterns,
// extremes, back-to-back stall, idle, mid-stream reset, early termination.
module tb_ifm_bsg_feeder;
  logic clk = 1'b0;
  logic rst;
  logic ifm_dff, en_i, clr_i, en_o, clr_o, mac_done, busy;

  always #5 clk = ~clk;

  ifm_bsg_feeder_if #(.IWIDTH(8)) bus();

  ifm_bsg_feeder #(.IWIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ifm      (bus),
    .ifm_dff  (ifm_dff),
    .en_i     (en_i),
    .clr_i    (clr_i),
    .en_o     (en_o),
    .clr_o    (clr_o),
    .mac_done (mac_done),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  // Output vector {ifm_dff,en_i,clr_i,en_o,clr_o,mac_done,busy}
  localparam logic [6:0] OUTS_RST  = 7'b0000000;
  localparam logic [6:0] OUTS_IDLE = 7'b0010000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {ifm_dff, en_i, clr_i, en_o, clr_o, mac_done, busy};
  endfunction

  task automatic offer(input logic [7:0] d, input logic f, input logic l);
    bus.ifm_valid = 1'b1;
    bus.ifm_data  = d;
    bus.ifm_first = f;
    bus.ifm_last  = l;
  endtask

  // Samples stream cycles k=0..len-1; entered at k=0, returns at k=len-1.
  task automatic collect(input int len, output int ones, output int n_clro, output int k_clro,
                         output int n_macd, output int k_macd, output int n_bad_ctl,
                         output int n_rdy_early, output logic rdy_last,
                         output logic [255:0] bits);
    ones = 0; n_clro = 0; k_clro = -1; n_macd = 0; k_macd = -1;
    n_bad_ctl = 0; n_rdy_early = 0; rdy_last = 1'b0; bits = '0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) step();
      bits[k] = ifm_dff;
      if (ifm_dff) ones++;
      if (clr_o) begin n_clro++; k_clro = k; end
      if (mac_done) begin n_macd++; k_macd = k; end
      if (!en_i || !en_o || clr_i || !busy) n_bad_ctl++;
      if (k < len - 1) begin
        if (bus.ifm_ready) n_rdy_early++;
      end else begin
        rdy_last = bus.ifm_ready;
      end
    end
  endtask

  int ones, n_clro, k_clro, n_macd, k_macd, n_bad_ctl, n_rdy_early, cnt_md;
  logic rdy_last;
  logic [255:0] bits;

  initial begin
    rst = 1'b1;
    bus.ifm_valid = 1'b0;
    bus.ifm_data  = '0;
    bus.ifm_first = 1'b0;
    bus.ifm_last  = 1'b0;
`ifdef BSG_EARLY_TERM_EN
    bus.len_log2  = 4'd8;
`endif
    step();
    step();
    chk("rst_outs", outs(), OUTS_RST);
    chk("rst_rdy", bus.ifm_ready, 0);

    rst = 1'b0;
    #1;
    chk("rdy_after_rst", bus.ifm_ready, 1);
    step();
    chk("idle_after_rst", outs(), OUTS_IDLE);

    // 128 first+last: alternating 1,0 pattern
    offer(8'd128, 1'b1, 1'b1);
    step();
    bus.ifm_valid = 1'b0;
    collect(256, ones, n_clro, k_clro, n_macd, k_macd, n_bad_ctl, n_rdy_early, rdy_last, bits);
    chk("d128_ones", ones, 128);
    chk("d128_b0", bits[0], 1);
    chk("d128_b1", bits[1], 0);
    chk("d128_b254", bits[254], 1);
    chk("d128_b255", bits[255], 0);
    chk("d128_nclro", n_clro, 1);
    chk("d128_kclro", k_clro, 0);
    chk("d128_nmacd", n_macd, 1);
    chk("d128_kmacd", k_macd, 255);
    chk("d128_ctl", n_bad_ctl, 0);
    chk("d128_rdy_early", n_rdy_early, 0);
    chk("d128_rdy_last", rdy_last, 1);
    step();
    chk("idle_outs", outs(), OUTS_IDLE);
    chk("idle_rdy", bus.ifm_ready, 1);
    for (int i = 0; i < 5; i++) step();
    chk("idle_outs_hold", outs(), OUTS_IDLE);
    chk("idle_rdy_hold", bus.ifm_ready, 1);

    // Extremes
    offer(8'd0, 1'b0, 1'b0);
    step();
    bus.ifm_valid = 1'b0;
    collect(256, ones, n_clro, k_clro, n_macd, k_macd, n_bad_ctl, n_rdy_early, rdy_last, bits);
    chk("d0_ones", ones, 0);
    chk("d0_ctl", n_bad_ctl, 0);
    chk("d0_nclro", n_clro, 0);
    chk("d0_nmacd", n_macd, 0);
    step();

    offer(8'd255, 1'b0, 1'b0);
    step();
    bus.ifm_valid = 1'b0;
    collect(256, ones, n_clro, k_clro, n_macd, k_macd, n_bad_ctl, n_rdy_early, rdy_last, bits);
    chk("d255_ones", ones, 255);
    chk("d255_b255", bits[255], 0);
    chk("d255_b254", bits[254], 1);
    chk("d255_ctl", n_bad_ctl, 0);
    step();

    // Back-to-back 37 (first) then 200 (last), valid held through the stall
    offer(8'd37, 1'b1, 1'b0);
    step();
    offer(8'd200, 1'b0, 1'b1);
    collect(256, ones, n_clro, k_clro, n_macd, k_macd, n_bad_ctl, n_rdy_early, rdy_last, bits);
    chk("b2b1_ones", ones, 37);
    chk("b2b1_nclro", n_clro, 1);
    chk("b2b1_nmacd", n_macd, 0);
    chk("b2b1_rdy_early", n_rdy_early, 0);
    chk("b2b1_rdy_last", rdy_last, 1);
    step();
    bus.ifm_valid = 1'b0;
    collect(256, ones, n_clro, k_clro, n_macd, k_macd, n_bad_ctl, n_rdy_early, rdy_last, bits);
    chk("b2b2_ones", ones, 200);
    chk("b2b2_ctl_nobubble", n_bad_ctl, 0);
    chk("b2b2_b0", bits[0], 1);
    chk("b2b2_nclro", n_clro, 0);
    chk("b2b2_nmacd", n_macd, 1);
    chk("b2b2_kmacd", k_macd, 255);
    step();
    chk("b2b_idle", outs(), OUTS_IDLE);

    // Reset at k=100 of a last=1 stream
    offer(8'd50, 1'b1, 1'b1);
    step();
    bus.ifm_valid = 1'b0;
    collect(101, ones, n_clro, k_clro, n_macd, k_macd, n_bad_ctl, n_rdy_early, rdy_last, bits);
    chk("mid_nmacd_pre", n_macd, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_outs", outs(), OUTS_RST);
    chk("mid_rst_rdy", bus.ifm_ready, 0);
    rst = 1'b0;
    step();
    chk("mid_rel_outs", outs(), OUTS_IDLE);
    chk("mid_rel_rdy", bus.ifm_ready, 1);
    cnt_md = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (mac_done || busy) cnt_md++;
    end
    chk("mid_no_macd", cnt_md, 0);

`ifdef BSG_EARLY_TERM_EN
    // len_log2=2, data=100: thresholds 0,128,64,192 -> 1,0,1,0
    bus.len_log2 = 4'd2;
    offer(8'd100, 1'b0, 1'b1);
    step();
    bus.ifm_valid = 1'b0;
    collect(4, ones, n_clro, k_clro, n_macd, k_macd, n_bad_ctl, n_rdy_early, rdy_last, bits);
    chk("et_bits", bits[3:0], 4'b0101);
    chk("et_kmacd", k_macd, 3);
    chk("et_nmacd", n_macd, 1);
    chk("et_rdy_early", n_rdy_early, 0);
    chk("et_rdy_last", rdy_last, 1);
    step();
    chk("et_idle", outs(), OUTS_IDLE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifm_bsg_feeder.md
Name: ifm_bsg_feeder

Overview:
- Row-edge input feeder for the rate-coded systolic array. It sits directly upstream of the first PE in each row.
- It accepts binary input-feature words over a valid/ready handshake and converts each word into a rate-coded bitstream (ifm_dff).
- It generates the per-row control strobes the PE chain consumes: en_i, clr_i, en_o, clr_o and mac_done.
- Random source is a bit-reversed counter, a 1-D low-discrepancy sequence, so a full-length stream carries exactly ifm ones.

Parameters:
- IWIDTH, 8, input word width; full stream length L = 2^IWIDTH cycles.
- LWIDTH, $clog2(IWIDTH+1), width of len_log2 (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- ifm_valid  in  1  upstream word valid.
- ifm_ready  out  1  feeder can accept a word this cycle.
- ifm_data  in  IWIDTH  unsigned input feature value.
- ifm_first  in  1  word is the first operand of a new accumulation; clears the PE accumulators.
- ifm_last  in  1  word is the last operand of the accumulation; raises mac_done.
- len_log2  in  LWIDTH  log2 stream length (present only with BSG_EARLY_TERM_EN).
- ifm_dff  out  1  rate-coded bit to PE ifm_dff.
- en_i  out  1  input-register enable.
- clr_i  out  1  input-register clear.
- en_o  out  1  accumulator enable.
- clr_o  out  1  accumulator clear.
- mac_done  out  1  one-cycle end-of-accumulation strobe.
- busy  out  1  stream in progress.

Behaviour:
- State machine:
  - States: IDLE and STREAM.
  - Registers: cnt (IWIDTH bits), data_q, first_q, last_q, lenm1_q (last count index).
- Handshake:
  - ifm_ready = !rst && (IDLE || (STREAM && cnt == lenm1_q)).
  - A word is accepted when ifm_valid && ifm_ready. At accept, data_q, first_q and last_q are latched, cnt is set to 0, and the state becomes STREAM.
  - ifm_ready does not depend on ifm_valid.
  - Holding ifm_valid without ready stalls without loss.
- Stream timing:
  - A word accepted in cycle t produces output stream cycles t+1 .. t+L.
  - All stream outputs are registered.
- Per stream cycle k (k = 0..L-1):
  - ifm_dff = (data_q > bitrev(k)), unsigned compare, where bitrev reverses all IWIDTH bits.
  - en_i = 1, en_o = 1, clr_i = 0, busy = 1.
  - clr_o = 1 only at k = 0 and only if first_q = 1.
  - mac_done = 1 only at k = L-1 and only if last_q = 1.
- End of stream:
  - At k = L-1, if no word is accepted, the next cycle is IDLE.
  - IDLE outputs: ifm_dff = 0, en_i = 0, en_o = 0, clr_o = 0, mac_done = 0, busy = 0, clr_i = 1 (holds the PE bit register at 0).
- Back-to-back:
  - An accept on the last stream cycle starts the next stream the following cycle with k = 0, with no bubble.
  - Output en_i stays high continuously across the boundary.
- Counter wrap: cnt never wraps inside a stream; it is reloaded to 0 on accept.
- Ones count: a full stream carries exactly ifm_data ones. ifm_data = 0 gives all zeros; ifm_data = 2^IWIDTH-1 gives a single zero, at k = L-1.
- Reset:
  - While rst is high, all state is cleared: IDLE, cnt = 0, data_q = 0, first_q = 0, last_q = 0.
  - Registered outputs go to ifm_dff = 0, en_i = 0, clr_i = 0, en_o = 0, clr_o = 0, mac_done = 0, busy = 0, and ifm_ready = 0.
  - The first cycle after rst drops: clr_i = 1, ifm_ready = 1.
- Reset mid-stream: the stream is abandoned, no mac_done is issued, and outputs follow the reset values on the next edge.
- Simultaneous ifm_first and ifm_last on one word: clr_o is raised at k = 0 and mac_done at k = L-1 of the same stream.

Optional Feature:
- Macro: BSG_EARLY_TERM_EN.
- With the macro defined:
  - The len_log2 port exists and is sampled at accept.
  - Stream length is 2^min(len_log2, IWIDTH); len_log2 = 0 gives length 1.
  - Compare is unchanged: data_q > bitrev(k) with full-width bitrev, so the truncated stream carries ceil(ifm_data / 2^(IWIDTH-len)) ones.
  - mac_done and ifm_ready track the shortened last cycle.
- Without the macro: there is no len_log2 port, and stream length is always 2^IWIDTH.

Test Plan:
- ifm_data = 128, first = 1, last = 1, IWIDTH = 8:
  - 256 stream cycles, with ifm_dff pattern 1,0,1,0,... (128 ones).
  - clr_o high in cycle t+1 only; mac_done high in cycle t+256 only; ifm_ready high only in cycle t+256 and afterwards.
- Extreme values:
  - ifm_data = 0 gives 0 ones.
  - ifm_data = 255 gives 255 ones, with the only 0 at k = 255.
  - In both cases en_i and en_o stay high for all 256 cycles.
- Back-to-back words 37 (first = 1), then 200 (last = 1), with valid held high:
  - The second word is accepted on cycle t+256, and there is no idle cycle between streams.
  - Stream ones counts are 37 and 200; exactly one clr_o and one mac_done.
- ifm_valid low after one stream: IDLE outputs clr_i = 1, en_i = 0, busy = 0, and ifm_ready = 1 indefinitely.
- rst asserted at k = 100 of a last = 1 stream: next cycle all outputs are 0 and no mac_done occurs. After release, clr_i = 1 and ifm_ready = 1.
- With BSG_EARLY_TERM_EN, len_log2 = 2, ifm_data = 100:
  - 4-cycle stream with bits 1,0,1,0 (compare values 0, 128, 64, 192).
  - mac_done at k = 3; ifm_ready high at k = 3.
